// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and FSM encoding for the dot-product sequencer
package mult_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int GUARD_DEF = 8;
  localparam int ACC_W_DEF = 2 * WIDTH_DEF + GUARD_DEF;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_GAP  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - radix-2 sequential Booth multiplier attached beside mult_dot_seq
// Starts on en, pulses done for one cycle, then waits for en to drop before rearming.
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic signed [WIDTH-1:0]   a,
  input  logic signed [WIDTH-1:0]   b,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] m
);

  localparam int PW = 2 * WIDTH + 2;

  logic [PW-1:0]          r_p;
  logic signed [WIDTH:0]  r_mcand;
  logic [7:0]             r_step;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_hold;
  logic signed [WIDTH:0]  w_upper;
  logic signed [WIDTH:0]  w_sum;
  logic [PW-1:0]          w_shift;

  // One extra upper bit keeps -(-2^(WIDTH-1)) representable during the add/sub.
  always_comb begin
    w_upper = r_p[PW-1:WIDTH+1];
    case (r_p[1:0])
      2'b01:   w_sum = w_upper + r_mcand;
      2'b10:   w_sum = w_upper - r_mcand;
      default: w_sum = w_upper;
    endcase
    w_shift = PW'($signed({w_sum, r_p[WIDTH:0]}) >>> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_mcand <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!en) r_hold <= 1'b0;
      if (r_busy) begin
        r_p    <= w_shift;
        r_step <= r_step + 8'd1;
        if (r_step == 8'(WIDTH - 1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_hold <= 1'b1;
        end
      end else if (en && !r_hold && !r_done) begin
        r_p     <= {{(WIDTH + 1){1'b0}}, b, 1'b0};
        r_mcand <= {a[WIDTH-1], a};
        r_step  <= '0;
        r_busy  <= 1'b1;
      end
    end
  end

  assign done = r_done;
  assign m    = r_p[2*WIDTH:1];

endmodule

// File: rtl/mult_dot_seq.sv
// rtl/mult_dot_seq.sv - sequences operand pairs through an external multiplier and accumulates
// the products into a guarded two's-complement sum.
module mult_dot_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [7:0]                      len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [WIDTH-1:0]         a_in,
  input  logic signed [WIDTH-1:0]         b_in,
  output logic                            mul_en,
  output logic signed [WIDTH-1:0]         mul_a,
  output logic signed [WIDTH-1:0]         mul_b,
  input  logic                            mul_done,
  input  logic signed [2*WIDTH-1:0]       mul_m,
  output logic                            sum_valid,
  input  logic                            out_ready,
  output logic signed [2*WIDTH+GUARD-1:0] sum
);

  localparam int ACC_W = acc_w(WIDTH, GUARD);

  state_t                   r_state;
  state_t                   w_next;
  logic [7:0]               r_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [WIDTH-1:0]  r_mul_a;
  logic signed [WIDTH-1:0]  r_mul_b;
  logic signed [ACC_W-1:0]  w_prod_ext;

  assign w_prod_ext = {{GUARD{mul_m[2*WIDTH-1]}}, mul_m};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == 8'd0) ? S_OUT : S_LOAD;
      S_LOAD:  if (in_valid) w_next = S_MUL;
      S_MUL:   if (mul_done) w_next = S_GAP;
      S_GAP:   w_next = (r_cnt == 8'd0) ? S_OUT : S_LOAD;
      S_OUT:   if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Data registers only move in their owning state, so stray start/mul_done pulses are inert.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= len;
            r_acc <= '0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_mul_a <= a_in;
            r_mul_b <= b_in;
          end
        end
        S_MUL: begin
          if (mul_done) begin
            r_acc <= r_acc + w_prod_ext;
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign mul_en    = (r_state == S_MUL);
  assign sum_valid = (r_state == S_OUT);
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign sum       = r_acc;

endmodule

// File: tb/tb_mult_dot_seq.sv
// tb/tb_mult_dot_seq.sv - directed bench for mult_dot_seq with booth_mult alongside
module tb_mult_dot_seq;
  import mult_pkg::*;

  localparam int W  = 8;
  localparam int G  = 8;
  localparam int AW = 2 * W + G;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [7:0]             len = 8'd0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic signed [W-1:0]    a_in = '0;
  logic signed [W-1:0]    b_in = '0;
  logic                   mul_en;
  logic signed [W-1:0]    mul_a;
  logic signed [W-1:0]    mul_b;
  logic                   bm_done;
  logic signed [2*W-1:0]  bm_m;
  logic                   force_done = 1'b0;
  logic signed [2*W-1:0]  force_m = '0;
  logic                   mul_done;
  logic signed [2*W-1:0]  mul_m;
  logic                   sum_valid;
  logic                   out_ready = 1'b0;
  logic signed [AW-1:0]   sum;

  int   total = 0;
  int   bad = 0;
  int   bursts = 0;
  int   b0 = 0;
  logic en_q = 1'b0;

  assign mul_done = bm_done | force_done;
  assign mul_m    = force_done ? force_m : bm_m;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_q <= mul_en;
    if (mul_en && !en_q) bursts <= bursts + 1;
  end

  mult_dot_seq #(.WIDTH(W), .GUARD(G)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_m(mul_m),
    .sum_valid(sum_valid), .out_ready(out_ready), .sum(sum)
  );

  booth_mult #(.WIDTH(W)) u_booth (
    .clk(clk), .rst_n(rst_n), .en(mul_en), .a(mul_a), .b(mul_b),
    .done(bm_done), .m(bm_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_pair(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                         input bit last);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("load_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mul_en_next", 32'(mul_en), 32'd1);
    chk("in_ready_mul", 32'(in_ready), 32'd0);
    chk("mul_a", 32'(mul_a), 32'(a));
    chk("mul_b", 32'(mul_b), 32'(b));
    n = 0;
    while (!mul_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(mul_done), 32'd1);
    @(negedge clk);
    chk("gap_mul_en", 32'(mul_en), 32'd0);
    chk("gap_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    if (last) chk("out_valid", 32'(sum_valid), 32'd1);
    else      chk("next_load", 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drained", 32'(sum_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_mul_en", 32'(mul_en), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_sum_valid", 32'(sum_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;

    // single term
    start = 1'b1; len = 8'd1; b0 = bursts;
    @(negedge clk);
    start = 1'b0;
    do_pair(-8'sd10, -8'sd100, 1'b1);
    chk("len1_sum", 32'(sum), 32'd1000);
    chk("len1_bursts", 32'(bursts - b0), 32'd1);
    drain();

    // extremes of the operand range
    start = 1'b1; len = 8'd3; b0 = bursts;
    @(negedge clk);
    start = 1'b0;
    do_pair(-8'sd128, -8'sd128, 1'b0);
    do_pair(8'sd127, 8'sd127, 1'b0);
    do_pair(-8'sd128, 8'sd127, 1'b1);
    chk("len3_sum", 32'(sum), 32'd16257);
    chk("len3_bursts", 32'(bursts - b0), 32'd3);
    drain();

    // empty dot product
    start = 1'b1; len = 8'd0; b0 = bursts;
    @(negedge clk);
    start = 1'b0;
    chk("len0_valid", 32'(sum_valid), 32'd1);
    chk("len0_sum", 32'(sum), 32'd0);
    chk("len0_mul_en", 32'(mul_en), 32'd0);
    drain();
    chk("len0_bursts", 32'(bursts - b0), 32'd0);

    // longest run, then backpressure on the result
    start = 1'b1; len = 8'd255;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 255; i++) do_pair(-8'sd128, -8'sd128, i == 254);
    chk("len255_sum", 32'(sum), 32'd4177920);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'd4177920);
      chk("hold_valid", 32'(sum_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd1;
    @(negedge clk);
    out_ready = 1'b0; start = 1'b0;
    chk("xfer_valid", 32'(sum_valid), 32'd0);
    chk("xfer_start_ignored", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("still_idle", 32'(in_ready), 32'd0);

    // reset while term 2 is in the multiplier
    start = 1'b1; len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    do_pair(8'sd5, 8'sd5, 1'b0);
    in_valid = 1'b1; a_in = 8'sd7; b_in = 8'sd9;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t2_mul_en", 32'(mul_en), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_mul_en", 32'(mul_en), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_sum_valid", 32'(sum_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_mul_a", 32'(mul_a), 32'd0);
    chk("arst_mul_b", 32'(mul_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1; len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    chk("first_start", 32'(in_ready), 32'd1);
    do_pair(8'sd3, 8'sd4, 1'b1);
    chk("post_rst_sum", 32'(sum), 32'd12);
    drain();

    // stray mul_done in IDLE, stray start in LOAD
    force_done = 1'b1; force_m = 16'sd1234;
    @(negedge clk);
    force_done = 1'b0;
    chk("stray_done_sum", 32'(sum), 32'd12);
    chk("stray_done_idle", 32'(in_ready), 32'd0);
    chk("stray_done_valid", 32'(sum_valid), 32'd0);
    chk("stray_done_mul_en", 32'(mul_en), 32'd0);
    start = 1'b1; len = 8'd2;
    @(negedge clk);
    start = 1'b1; len = 8'd0;
    chk("load_entered", 32'(in_ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    chk("stray_start_load", 32'(in_ready), 32'd1);
    chk("stray_start_valid", 32'(sum_valid), 32'd0);
    do_pair(8'sd2, 8'sd3, 1'b0);
    do_pair(-8'sd4, 8'sd5, 1'b1);
    chk("neg_sum", 32'(sum), 32'hFFFF_FFF2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
